// File: rtl/mac_pkg.sv
// Shared types and sizes for the tile output stage.
// Build option: OSTAGE_SAT_EN selects saturating lane sums (see ostage_lane_add).
package mac_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = 16;
  localparam int ROWS   = 4;
  localparam int OM_AW  = 6;
  localparam int ROW_W  = 2;
  localparam int DST_W  = 4;
  localparam int DATA_W = LANES * LANE_W;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } ostage_state_t;

endpackage

// File: rtl/ostage_lane_add.sv
// One signed 16-bit lane of the accumulator update: overwrite on the first
// pass, otherwise add. With OSTAGE_SAT_EN defined the sum clamps to
// [-32768, 32767]; without it the sum wraps modulo 2^16.
module ostage_lane_add
  import mac_pkg::*;
(
  input  logic [LANE_W-1:0] acc_in,
  input  logic [LANE_W-1:0] data_in,
  input  logic              first,
  output logic [LANE_W-1:0] sum
);

`ifdef OSTAGE_SAT_EN
  logic [LANE_W:0] wide;

  // Sign-extended add, then clamp when the two top bits disagree (overflow).
  always_comb begin
    wide = {acc_in[LANE_W-1], acc_in} + {data_in[LANE_W-1], data_in};
    if (first) begin
      sum = data_in;
    end else if (wide[LANE_W] != wide[LANE_W-1]) begin
      sum = wide[LANE_W] ? {1'b1, {(LANE_W-1){1'b0}}} : {1'b0, {(LANE_W-1){1'b1}}};
    end else begin
      sum = wide[LANE_W-1:0];
    end
  end
`else
  // Plain two's complement add; the carry out is dropped.
  always_comb begin
    if (first) begin
      sum = data_in;
    end else begin
      sum = acc_in + data_in;
    end
  end
`endif

endmodule

// File: rtl/tile_output_stage.sv
// Tile output stage: collects the four result rows of a tile pass into a
// row accumulator, and on the last pass writes the tile out to output memory.
// Build option: OSTAGE_SAT_EN (saturating lane sums, no port change).
//
// Handshake: RES_VALID is a one-cycle strobe with no ready/back-pressure; a
// row is taken on the clock edge where RES_VALID=1 only in COLLECT for a row
// not yet received this pass, every other strobe is dropped and sets ERR.
// START_CALC is a level that must stay high for the whole pass; dropping it
// during COLLECT abandons the pass.
module tile_output_stage
  import mac_pkg::*;
(
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              START_CALC,
  input  logic              PASS_FIRST,
  input  logic              PASS_LAST,
  input  logic [DST_W-1:0]  ODST,
  input  logic              RES_VALID,
  input  logic [ROW_W-1:0]  RES_ROW,
  input  logic [DATA_W-1:0] RES_DATA,
  output logic              OM_WE,
  output logic [OM_AW-1:0]  OM_ADDR,
  output logic [DATA_W-1:0] OM_WDATA,
  output logic              Tile_Done,
  output logic              ERR
);

  ostage_state_t     state;
  logic [ROWS-1:0]   mask;
  logic [ROWS-1:0]   mask_next;
  logic [DST_W-1:0]  tile_dst;
  logic              first_l;
  logic              last_l;
  logic [ROW_W-1:0]  wr_row;
  logic              err;
  logic [DATA_W-1:0] acc [ROWS];
  logic [DATA_W-1:0] acc_sel;
  logic [DATA_W-1:0] acc_new;
  logic              row_new;
  logic              accept;

  // Row bookkeeping for the strobe currently on the inputs.
  always_comb begin
    acc_sel   = acc[RES_ROW];
    row_new   = ~mask[RES_ROW];
    mask_next = mask | (ROWS'(1) << RES_ROW);
    accept    = (state == ST_COLLECT) && START_CALC && RES_VALID && row_new;
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    ostage_lane_add u_lane (
      .acc_in  (acc_sel[i*LANE_W +: LANE_W]),
      .data_in (RES_DATA[i*LANE_W +: LANE_W]),
      .first   (first_l),
      .sum     (acc_new[i*LANE_W +: LANE_W])
    );
  end

  // Pass sequencing: latch pass context, track received rows, walk the write-out.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state    <= ST_IDLE;
      mask     <= '0;
      tile_dst <= '0;
      first_l  <= 1'b0;
      last_l   <= 1'b0;
      wr_row   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (START_CALC) begin
            state    <= ST_COLLECT;
            tile_dst <= ODST;
            first_l  <= PASS_FIRST;
            last_l   <= PASS_LAST;
            mask     <= '0;
          end
        end
        ST_COLLECT: begin
          if (!START_CALC) begin
            state <= ST_IDLE;
          end else if (accept) begin
            mask <= mask_next;
            if (&mask_next) begin
              state  <= last_l ? ST_WRITE : ST_DONE;
              wr_row <= '0;
            end
          end
        end
        ST_WRITE: begin
          wr_row <= wr_row + 1'b1;
          if (wr_row == ROW_W'(ROWS - 1)) begin
            state <= ST_DONE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Accumulator rows; only a freshly accepted row is written.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int r = 0; r < ROWS; r++) begin
        acc[r] <= '0;
      end
    end else if (accept) begin
      acc[RES_ROW] <= acc_new;
    end
  end

  // Sticky protocol error: any strobe that is not a fresh row in COLLECT.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      err <= 1'b0;
    end else if (RES_VALID && ((state != ST_COLLECT) || !row_new)) begin
      err <= 1'b1;
    end
  end

  // Outputs decode the registered state, so they drop with RSTN at once.
  always_comb begin
    OM_WE     = (state == ST_WRITE);
    OM_ADDR   = OM_WE ? {tile_dst, wr_row} : '0;
    OM_WDATA  = OM_WE ? acc[wr_row] : '0;
    Tile_Done = (state == ST_DONE);
    ERR       = err;
  end

endmodule

// File: tb/tb_tile_output_stage.sv
// Directed bench for tile_output_stage; expected values are hand-computed.
module tb_tile_output_stage;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start_calc;
  logic        pass_first;
  logic        pass_last;
  logic [3:0]  odst;
  logic        res_valid;
  logic [1:0]  res_row;
  logic [63:0] res_data;
  logic        om_we;
  logic [5:0]  om_addr;
  logic [63:0] om_wdata;
  logic        tile_done;
  logic        err;

  int checks   = 0;
  int failures = 0;

  tile_output_stage dut (
    .CLK        (clk),
    .RSTN       (rstn),
    .START_CALC (start_calc),
    .PASS_FIRST (pass_first),
    .PASS_LAST  (pass_last),
    .ODST       (odst),
    .RES_VALID  (res_valid),
    .RES_ROW    (res_row),
    .RES_DATA   (res_data),
    .OM_WE      (om_we),
    .OM_ADDR    (om_addr),
    .OM_WDATA   (om_wdata),
    .Tile_Done  (tile_done),
    .ERR        (err)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic logic [63:0] lanes4(input logic [15:0] v);
    return {v, v, v, v};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pass(input logic [3:0] dst, input logic first, input logic last);
    start_calc = 1'b1;
    odst       = dst;
    pass_first = first;
    pass_last  = last;
    step();
  endtask

  task automatic send_row(input logic [1:0] row, input logic [63:0] data);
    res_valid = 1'b1;
    res_row   = row;
    res_data  = data;
    step();
    res_valid = 1'b0;
    res_data  = '0;
  endtask

  task automatic check_write(input string tag, input logic [5:0] addr, input logic [63:0] data);
    chk({tag, "_we"},   om_we,     64'd1);
    chk({tag, "_addr"}, om_addr,   64'(addr));
    chk({tag, "_data"}, om_wdata,  data);
    chk({tag, "_done"}, tile_done, 64'd0);
    step();
  endtask

  task automatic check_done(input string tag);
    chk({tag, "_done"},    tile_done, 64'd1);
    chk({tag, "_we_low"},  om_we,     64'd0);
    step();
    chk({tag, "_done_end"}, tile_done, 64'd0);
  endtask

  initial begin
    logic [63:0] exp_lo;
    logic [63:0] d0, d1, d2, d3;

    // Reset
    rstn = 1'b0; start_calc = 0; pass_first = 0; pass_last = 0;
    odst = '0; res_valid = 0; res_row = '0; res_data = '0;
    step(); step();
    chk("rst_we",    om_we,     64'd0);
    chk("rst_addr",  om_addr,   64'd0);
    chk("rst_wdata", om_wdata,  64'd0);
    chk("rst_done",  tile_done, 64'd0);
    chk("rst_err",   err,       64'd0);
    rstn = 1'b1;

    // Single first+last pass, rows out of order, writes at 0x14..0x17, done at k+5
    start_pass(4'h5, 1'b1, 1'b1);
    send_row(2'd3, lanes4(16'h0001));
    send_row(2'd0, lanes4(16'h0001));
    send_row(2'd2, lanes4(16'h0001));
    chk("t1_no_we_collect", om_we, 64'd0);
    send_row(2'd1, lanes4(16'h0001));
    start_calc = 1'b0;
    check_write("t1_w0", 6'h14, 64'h0001000100010001);
    check_write("t1_w1", 6'h15, 64'h0001000100010001);
    check_write("t1_w2", 6'h16, 64'h0001000100010001);
    check_write("t1_w3", 6'h17, 64'h0001000100010001);
    check_done("t1");
    chk("t1_err", err, 64'd0);

    // Two passes to 0x2: first pass finishes at k+1 with no write, second writes 6
    start_pass(4'h2, 1'b1, 1'b0);
    for (int r = 0; r < 4; r++) send_row(2'(r), lanes4(16'h0003));
    start_calc = 1'b0;
    check_done("t2a");
    start_pass(4'h2, 1'b0, 1'b1);
    for (int r = 0; r < 4; r++) send_row(2'(r), lanes4(16'h0003));
    start_calc = 1'b0;
    check_write("t2_w0", 6'h08, lanes4(16'h0006));
    check_write("t2_w1", 6'h09, lanes4(16'h0006));
    check_write("t2_w2", 6'h0A, lanes4(16'h0006));
    check_write("t2_w3", 6'h0B, lanes4(16'h0006));
    check_done("t2b");

    // Overflow: lane0 7FFF+0001, lane1 8000+FFFF
`ifdef OSTAGE_SAT_EN
    exp_lo = 64'h0000_0000_8000_7FFF;
`else
    exp_lo = 64'h0000_0000_7FFF_8000;
`endif
    start_pass(4'hA, 1'b1, 1'b0);
    for (int r = 0; r < 4; r++) send_row(2'(r), 64'h0000_0000_8000_7FFF);
    start_calc = 1'b0;
    check_done("t3a");
    start_pass(4'hA, 1'b0, 1'b1);
    for (int r = 0; r < 4; r++) send_row(2'(r), 64'h0000_0000_FFFF_0001);
    start_calc = 1'b0;
    check_write("t3_w0", 6'h28, exp_lo);
    check_write("t3_w1", 6'h29, exp_lo);
    check_write("t3_w2", 6'h2A, exp_lo);
    check_write("t3_w3", 6'h2B, exp_lo);
    check_done("t3b");
    chk("t3_err", err, 64'd0);

    // Duplicate row 2: ERR set, second copy discarded, pass completes
    start_pass(4'h1, 1'b1, 1'b1);
    send_row(2'd2, lanes4(16'h0002));
    chk("t4_err_before", err, 64'd0);
    send_row(2'd2, lanes4(16'h0099));
    chk("t4_err_dup", err, 64'd1);
    send_row(2'd0, lanes4(16'h0001));
    send_row(2'd1, lanes4(16'h0001));
    send_row(2'd3, lanes4(16'h0001));
    start_calc = 1'b0;
    check_write("t4_w0", 6'h04, lanes4(16'h0001));
    check_write("t4_w1", 6'h05, lanes4(16'h0001));
    check_write("t4_w2", 6'h06, lanes4(16'h0002));
    check_write("t4_w3", 6'h07, lanes4(16'h0001));
    check_done("t4");
    chk("t4_err_sticky", err, 64'd1);

    // Abort after 2 rows: no done, acc kept (rows 0,1 become 0x0011)
    start_pass(4'h3, 1'b0, 1'b0);
    send_row(2'd0, lanes4(16'h0010));
    send_row(2'd1, lanes4(16'h0010));
    start_calc = 1'b0;
    step();
    chk("t5_abort_done", tile_done, 64'd0);
    chk("t5_abort_we",   om_we,     64'd0);
    step();
    chk("t5_abort_done2", tile_done, 64'd0);

    // Next pass adds 0x0100 on top of retained acc; reset during write row 1
    start_pass(4'h3, 1'b0, 1'b1);
    for (int r = 0; r < 4; r++) send_row(2'(r), lanes4(16'h0100));
    start_calc = 1'b0;
    check_write("t5_w0", 6'h0C, lanes4(16'h0111));
    chk("t5_w1_we",   om_we,    64'd1);
    chk("t5_w1_addr", om_addr,  64'h0D);
    chk("t5_w1_data", om_wdata, lanes4(16'h0111));
    rstn = 1'b0;
    #1;
    chk("t5_rst_we",    om_we,     64'd0);
    chk("t5_rst_addr",  om_addr,   64'd0);
    chk("t5_rst_wdata", om_wdata,  64'd0);
    chk("t5_rst_done",  tile_done, 64'd0);
    chk("t5_rst_err",   err,       64'd0);

    // Start on the first edge after release; acc was cleared, so sums equal data
    start_calc = 1'b1; odst = 4'hF; pass_first = 1'b0; pass_last = 1'b1;
    #2;
    rstn = 1'b1;
    step();
    d0 = 64'h1111_2222_3333_4444;
    d1 = 64'h8000_7FFF_0001_FFFF;
    d2 = 64'h0102_0304_0506_0708;
    d3 = 64'hFFFE_0010_ABCD_1234;
    send_row(2'd1, d1);
    send_row(2'd3, d3);
    send_row(2'd0, d0);
    send_row(2'd2, d2);
    start_calc = 1'b0;
    check_write("t6_w0", 6'h3C, d0);
    check_write("t6_w1", 6'h3D, d1);
    check_write("t6_w2", 6'h3E, d2);
    check_write("t6_w3", 6'h3F, d3);
    check_done("t6");
    chk("t6_err", err, 64'd0);

    // Strobe while idle is a protocol error
    send_row(2'd0, lanes4(16'h0005));
    chk("t7_idle_err", err, 64'd1);
    chk("t7_idle_we",  om_we, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
